sextium_mem_arbiter: RTL and testbench

SEXTIUM_MEM_ARBITER -- requirements
Module: sextium_mem_arbiter

---
 rtl/sextium_pkg.sv | 15 +
 rtl/sextium_rr_arbiter.sv | 17 +
 rtl/sextium_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_sextium_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sextium_pkg.sv
// Shared definitions for the Sextium memory arbiter: default widths, timeout
// and the arbiter FSM state type.
package sextium_pkg;

    localparam int unsigned AW_DEF      = 16;
    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sextium_rr_arbiter.sv
// Two-way round-robin pick: grant 0 selects m0, 1 selects m1. Only meaningful
// while at least one request is pending.
module sextium_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = req[1];
        // On a tie the requester not served last wins.
        if (req == 2'b11) begin
            grant = ~last;
        end
    end

endmodule

// File: rtl/sextium_mem_arbiter.sv
// Arbitrates two requesters (core m0, loader/debug m1) onto one memory port,
// with a bounded wait for mem_ack and a one-cycle DONE gap per transaction.
module sextium_mem_arbiter
    import sextium_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    state_t        r_state;
    logic          r_last;
    logic          r_gnt;
    logic [7:0]    r_cnt;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;
    logic          r_m0_ack;
    logic          r_m1_ack;
    logic          r_m0_err;
    logic          r_m1_err;

    logic [1:0]    w_req;
    logic          w_gnt;
    logic          w_sel_write;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_req       = {m1_read | m1_write, m0_read | m0_write};
    assign w_sel_write = w_gnt ? m1_write : m0_write;
    assign w_sel_addr  = w_gnt ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt ? m1_wdata : m0_wdata;

    sextium_rr_arbiter u_rr (
        .req   (w_req),
        .last  (r_last),
        .grant (w_gnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_cnt       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_ack    <= 1'b0;
            r_m1_ack    <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_gnt       <= w_gnt;
                        r_last      <= w_gnt;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        // Read+write together is serviced as a write.
                        r_mem_write <= w_sel_write;
                        r_mem_read  <= ~w_sel_write;
                        r_cnt       <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_gnt) begin
                            r_m1_ack <= 1'b1;
                            if (r_mem_read) r_m1_rdata <= mem_rdata;
                        end else begin
                            r_m0_ack <= 1'b1;
                            if (r_mem_read) r_m0_rdata <= mem_rdata;
                        end
                        r_state <= ST_DONE;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_gnt) r_m1_err <= 1'b1;
                        else       r_m0_err <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_m0_err <= 1'b0;
                    r_m1_err <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_err    = r_m0_err;
    assign m1_err    = r_m1_err;

endmodule

// File: tb/tb_sextium_mem_arbiter.sv
// Bench for sextium_mem_arbiter: a memory responder with programmable ack delay
// and a transaction-level model of grant order, ack/err outcome and data.
module tb_sextium_mem_arbiter;

    localparam int TMO = 8;

    typedef struct {
        bit          rst;
        bit          r0, w0, r1, w1;
        logic [15:0] a0, a1, d0, d1;
        int          dly;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_read = 1'b0, m0_write = 1'b0;
    logic [15:0] m0_addr = '0, m0_wdata = '0;
    logic [15:0] m0_rdata;
    logic        m0_ack, m0_err;
    logic        m1_read = 1'b0, m1_write = 1'b0;
    logic [15:0] m1_addr = '0, m1_wdata = '0;
    logic [15:0] m1_rdata;
    logic        m1_ack, m1_err;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack;
    logic        r_resp_ack = 1'b0;
    logic        spurious = 1'b0;

    int          resp_delay = 0;
    int          wcnt = 0;
    logic [15:0] dev_mem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] exp_rdata [2];
    int          last_g;
    int          n_vec = 0;
    int          n_err = 0;
    rec_t        tbl [9];

    assign mem_ack = r_resp_ack | spurious;

    always #5 clock = ~clock;

    sextium_mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Memory device: acks on the resp_delay-th cycle the strobe is seen; 0 = never.
    always @(negedge clock) begin
        if (mem_read | mem_write) begin
            if (r_resp_ack) begin
                r_resp_ack = 1'b0;
            end else begin
                wcnt = wcnt + 1;
                if (resp_delay != 0 && wcnt == resp_delay) begin
                    r_resp_ack = 1'b1;
                    if (mem_write) dev_mem[mem_addr[7:0]] = mem_wdata;
                    else           mem_rdata = dev_mem[mem_addr[7:0]];
                end
            end
        end else begin
            wcnt = 0;
            r_resp_ack = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input rec_t v);
        m0_read = v.r0; m0_write = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_read = v.r1; m1_write = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_g = 1;
        @(negedge clock); #1;
    endtask

    task automatic run_round(input rec_t v);
        bit          p [2];
        bit          wr [2];
        bit          done [2];
        logic [15:0] a [2];
        logic [15:0] d [2];
        int          nacc [2];
        int          nerr [2];
        int          seq [2];
        int          first, second, cur, order_first, strobes, exp_strobes;
        bit          ok;
        if (v.rst) do_reset();
        p[0] = v.r0 | v.w0; p[1] = v.r1 | v.w1;
        wr[0] = v.w0; wr[1] = v.w1;
        a[0] = v.a0; a[1] = v.a1; d[0] = v.d0; d[1] = v.d1;
        ok = (v.dly >= 1 && v.dly <= TMO);
        first = -1; second = -1;
        if (p[0] && p[1]) begin
            first = (last_g == 1) ? 0 : 1;
            second = 1 - first;
        end else if (p[0]) first = 0;
        else if (p[1]) first = 1;
        done[0] = !p[0]; done[1] = !p[1];
        nacc[0] = 0; nacc[1] = 0; nerr[0] = 0; nerr[1] = 0;
        order_first = -1; strobes = 0;
        resp_delay = v.dly;
        drive(v);
        for (int c = 0; c < 80; c++) begin
            @(negedge clock); #1;
            if (c == 0 && first >= 0) check("grant_latency", 32'(mem_read | mem_write), 1);
            check("strobe_exclusive", 32'(mem_read & mem_write), 0);
            if (mem_read | mem_write) begin
                strobes++;
                cur = (first >= 0 && !done[first]) ? first : second;
                if (cur < 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    check("mem_addr", mem_addr, a[cur]);
                    check("mem_write", 32'(mem_write), 32'(wr[cur]));
                    if (wr[cur]) check("mem_wdata", mem_wdata, d[cur]);
                end
            end
            if (m0_ack) nacc[0]++;
            if (m1_ack) nacc[1]++;
            if (m0_err) nerr[0]++;
            if (m1_err) nerr[1]++;
            if ((m0_ack | m0_err) && !done[0]) begin
                done[0] = 1; if (order_first < 0) order_first = 0;
                m0_read = 0; m0_write = 0;
            end
            if ((m1_ack | m1_err) && !done[1]) begin
                done[1] = 1; if (order_first < 0) order_first = 1;
                m1_read = 0; m1_write = 0;
            end
            if (done[0] && done[1] && !(mem_read | mem_write)) break;
        end
        check("round_complete", 32'(done[0] & done[1]), 1);
        exp_strobes = 0;
        seq[0] = first; seq[1] = second;
        for (int k = 0; k < 2; k++) begin
            if (seq[k] >= 0) begin
                exp_strobes += ok ? v.dly : TMO;
                if (ok) begin
                    if (wr[seq[k]]) ref_mem[a[seq[k]][7:0]] = d[seq[k]];
                    else            exp_rdata[seq[k]] = ref_mem[a[seq[k]][7:0]];
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("m%0d_ack_pulses", i), nacc[i], 32'(p[i] && ok));
            check($sformatf("m%0d_err_pulses", i), nerr[i], 32'(p[i] && !ok));
        end
        check("m0_rdata", m0_rdata, exp_rdata[0]);
        check("m1_rdata", m1_rdata, exp_rdata[1]);
        if (second >= 0) check("grant_order", order_first, first);
        check("strobe_cycles", strobes, exp_strobes);
        if (second >= 0) last_g = second;
        else if (first >= 0) last_g = first;
        @(negedge clock); #1;
        check("quiet_after_done", {26'd0, m0_ack, m0_err, m1_ack, m1_err, mem_read, mem_write}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rec_t rv;
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 16'(i * 37 + 16'h0100);
            ref_mem[i] = 16'(i * 37 + 16'h0100);
        end
        dev_mem[8'h10] = 16'hBEEF;
        ref_mem[8'h10] = 16'hBEEF;

        //           rst r0 w0 r1 w1   a0        a1        d0        d1       dly
        tbl[0] = '{1'b1, 1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2};
        tbl[1] = '{1'b1, 0, 1, 0, 1, 16'h0001, 16'h0002, 16'h1111, 16'h2222, 2};
        tbl[2] = '{1'b0, 1, 0, 1, 0, 16'h0002, 16'h0001, 16'h0000, 16'h0000, 3};
        tbl[3] = '{1'b0, 1, 0, 1, 0, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 1};
        tbl[4] = '{1'b0, 0, 0, 1, 0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 0};
        tbl[5] = '{1'b0, 1, 1, 0, 0, 16'h0003, 16'h0000, 16'h5A5A, 16'h0000, 1};
        tbl[6] = '{1'b0, 1, 0, 0, 0, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 8};
        tbl[7] = '{1'b0, 0, 0, 0, 1, 16'h0000, 16'h0004, 16'h0000, 16'hDEAD, 9};
        tbl[8] = '{1'b0, 0, 0, 1, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 1};

        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_g = 1;
        repeat (2) @(negedge clock);
        #1;
        check("reset_state", {m0_rdata, m1_rdata}, 0);
        check("reset_strobes", {26'd0, m0_ack, m0_err, m1_ack, m1_err, mem_read, mem_write}, 0);
        check("reset_mem_addr", {mem_addr, mem_wdata}, 0);
        reset = 1'b0;
        @(negedge clock); #1;

        for (int i = 0; i < 9; i++) run_round(tbl[i]);

        // Spurious mem_ack while idle must have no effect.
        spurious = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check("idle_ack_ignored", {26'd0, m0_ack, m0_err, m1_ack, m1_err, mem_read, mem_write}, 0);
        end
        spurious = 1'b0;
        @(negedge clock); #1;

        // Reset in the middle of a transaction aborts it asynchronously.
        rv = '{1'b0, 1, 0, 0, 0, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 0};
        resp_delay = 0;
        drive(rv);
        repeat (3) @(negedge clock);
        #1;
        check("busy_before_reset", 32'(mem_read), 1);
        check("m0_rdata_before_reset", 32'(m0_rdata != 16'h0000), 1);
        reset = 1'b1;
        #1;
        check("async_reset_strobes", {30'd0, mem_read, mem_write}, 0);
        check("async_reset_addr", {mem_addr, mem_wdata}, 0);
        check("async_reset_rdata", {m0_rdata, m1_rdata}, 0);
        m0_read = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check("reset_no_pulse", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 0);
        end
        reset = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_g = 1;
        @(negedge clock); #1;
        rv = '{1'b0, 1, 0, 1, 0, 16'h0010, 16'h0003, 16'h0000, 16'h0000, 2};
        run_round(rv);

        for (int n = 0; n < 40; n++) begin
            rv.rst = 1'b0;
            rv.r0  = 1'($urandom_range(0, 1));
            rv.w0  = 1'($urandom_range(0, 1));
            rv.r1  = 1'($urandom_range(0, 1));
            rv.w1  = 1'($urandom_range(0, 1));
            rv.a0  = 16'($urandom_range(0, 255));
            rv.a1  = 16'($urandom_range(0, 255));
            rv.d0  = 16'($urandom);
            rv.d1  = 16'($urandom);
            rv.dly = int'($urandom_range(0, 10));
            run_round(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
